// File: rtl/dmem_vga_arbiter_if.sv
// Bus bundle around the shared data-memory arbiter.
//   CPU side : cpu_we, cpu_re, cpu_addr, cpu_wd -> arbiter; cpu_rd, cpu_stall <- arbiter
//   VGA side : vga_start, vga_base, vga_len, vga_ready -> arbiter;
//              vga_data, vga_valid, vga_busy, vga_done <- arbiter
//   Memory   : mem_we, mem_addr, mem_wd <- arbiter; mem_rd -> arbiter (combinational read)
// Modports: slave = the arbiter's view, master = the surrounding system's view.
//
// VGA read handshake: vga_data is the FIFO head and is meaningful only while
// vga_valid=1; a word is consumed on every rising edge where vga_valid and
// vga_ready are both 1. vga_ready may be driven freely and a ready with no
// valid word has no effect.
interface dmem_vga_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
);
  logic              cpu_we;
  logic              cpu_re;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wd;
  logic [DATA_W-1:0] cpu_rd;
  logic              cpu_stall;

  logic              vga_start;
  logic [ADDR_W-1:0] vga_base;
  logic [LEN_W-1:0]  vga_len;
  logic [DATA_W-1:0] vga_data;
  logic              vga_valid;
  logic              vga_ready;
  logic              vga_busy;
  logic              vga_done;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  modport slave (
    input  cpu_we, cpu_re, cpu_addr, cpu_wd,
    input  vga_start, vga_base, vga_len, vga_ready,
    input  mem_rd,
    output cpu_rd, cpu_stall,
    output vga_data, vga_valid, vga_busy, vga_done,
    output mem_we, mem_addr, mem_wd
  );

  modport master (
    output cpu_we, cpu_re, cpu_addr, cpu_wd,
    output vga_start, vga_base, vga_len, vga_ready,
    output mem_rd,
    input  cpu_rd, cpu_stall,
    input  vga_data, vga_valid, vga_busy, vga_done,
    input  mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/dmem_vga_arbiter.sv
// Shares the single-port data memory between the pipeline MEMORY stage and a
// VGA pixel reader. The CPU has priority; VGA burst reads use idle slots and
// fill a small read FIFO. After MAX_CPU_RUN consecutive slots that the CPU won
// only by priority, one VGA slot is forced and the CPU is stalled for it.
// Ports:
//   clk      : system clock, all state on the rising edge
//   reset    : asynchronous, active-low reset
//   bus      : dmem_vga_arbiter_if.slave (CPU, VGA and memory signals)
//   dbgState : current burst FSM state (IDLE=0, BURST=1, DRAIN=2, DONE=3)
module dmem_vga_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_CPU_RUN = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_vga_arbiter_if.slave     bus,
  output logic [1:0]            dbgState
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RUN_W = $clog2(MAX_CPU_RUN + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] baseQ;
  logic [LEN_W-1:0]  lenQ;
  logic [LEN_W-1:0]  issued;
  logic [DATA_W-1:0] fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  count;
  logic [RUN_W-1:0]  run;

  logic cpuAct;
  logic fifoFull;
  logic fifoEmpty;
  logic forceVga;
  logic vgaCan;
  logic vgaSlot;
  logic push;
  logic pop;

  always_comb begin
    cpuAct    = bus.cpu_we | bus.cpu_re;
    fifoFull  = (count == CNT_W'(FIFO_DEPTH));
    fifoEmpty = (count == '0);
    forceVga  = (run == RUN_W'(MAX_CPU_RUN));
    // A VGA read could use this slot; fullness is judged before any pop this
    // cycle, so a full FIFO never accepts a word even while being popped.
    vgaCan    = (state == BURST) && (issued < lenQ) && !fifoFull;
    vgaSlot   = vgaCan && (!cpuAct || forceVga);
    push      = vgaSlot;
    pop       = !fifoEmpty && bus.vga_ready;
  end

  always_comb begin
    bus.cpu_stall = cpuAct && vgaSlot;
    bus.cpu_rd    = bus.mem_rd;
    bus.mem_wd    = bus.cpu_wd;
    bus.mem_addr  = vgaSlot ? (baseQ + (ADDR_W'(issued) << 2)) : bus.cpu_addr;
    // Gated by reset so no CPU write leaks into memory while held in reset;
    // a write during a VGA-owned slot is simply dropped (the CPU is stalled).
    bus.mem_we    = reset && bus.cpu_we && !vgaSlot;
    bus.vga_data  = fifoMem[rdPtr];
    bus.vga_valid = !fifoEmpty;
    bus.vga_busy  = (state != IDLE);
    bus.vga_done  = (state == DONE);
    dbgState      = state;
  end

  // FIFO storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr] <= bus.mem_rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      baseQ  <= '0;
      lenQ   <= '0;
      issued <= '0;
      wrPtr  <= '0;
      rdPtr  <= '0;
      count  <= '0;
      run    <= '0;
    end else begin
      if (push) begin
        wrPtr  <= wrPtr + PTR_W'(1);
        issued <= issued + LEN_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // The run counter only grows on slots the CPU took purely by priority.
      // A VGA slot taken while the CPU is active can only be a forced one.
      if (!cpuAct) begin
        run <= '0;
      end else if (state == BURST) begin
        if (vgaSlot) begin
          run <= '0;
        end else if (vgaCan) begin
          run <= run + RUN_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (bus.vga_start) begin
            state  <= BURST;
            baseQ  <= bus.vga_base;
            lenQ   <= bus.vga_len;
            issued <= '0;
          end
        end
        BURST: begin
          if (issued == lenQ) state <= DRAIN;
        end
        DRAIN: begin
          if (fifoEmpty) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_vga_arbiter.sv
module tb_dmem_vga_arbiter;

  localparam int S_IDLE  = 0;
  localparam int S_BURST = 1;
  localparam int S_DRAIN = 2;
  localparam int S_DONE  = 3;
  localparam int DEPTH   = 4;
  localparam int MAXRUN  = 8;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       reset;
  logic [1:0] dbgState;
  logic       memLoad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_vga_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(16)) bus ();

  dmem_vga_arbiter #(
    .ADDR_W(32), .DATA_W(32), .LEN_W(16), .FIFO_DEPTH(4), .MAX_CPU_RUN(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbgState(dbgState)
  );

  // ---------------- data memory (1K words, combinational read) ----------------
  logic [31:0] mem [0:1023];

  function automatic logic [31:0] pat(input int i);
    return 32'(i) * 32'h9E37_79B9 + 32'h1357_0000;
  endfunction

  assign bus.mem_rd = mem[bus.mem_addr[11:2]];

  always @(posedge clk) begin
    if (memLoad) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[11:2]] <= bus.mem_wd;
    end
  end

  // ---------------- reference model state ----------------
  logic [31:0] refMem [0:1023];
  int          mState;
  logic [31:0] mBase;
  int          mLen;
  int          mIssued;
  int          mRun;
  logic [31:0] mFifo [$];

  logic        eAct, eCan, eOwns, eWe;
  logic [31:0] eAddr;

  // ---------------- scoreboard / observations ----------------
  int          total;
  int          bad;
  int          cycleIdx;
  int          stallBase;
  int          doneCount;
  int          busyCount;
  int          vgaIssues;
  logic [31:0] rxQ [$];
  int          stallLog [$];

  task automatic modelReset();
    mState  = S_IDLE;
    mBase   = 32'd0;
    mLen    = 0;
    mIssued = 0;
    mRun    = 0;
    mFifo.delete();
  endtask

  // Compare every DUT output with the model's view of the current cycle.
  task automatic checkCycle();
    logic        act, can, owns, we;
    logic [31:0] addr;
    act  = bus.cpu_we | bus.cpu_re;
    can  = (mState == S_BURST) && (mIssued < mLen) && (mFifo.size() < DEPTH);
    owns = can && (!act || (mRun == MAXRUN));
    we   = bus.cpu_we && !owns;
    addr = owns ? (mBase + 32'(mIssued * 4)) : bus.cpu_addr;

    total++;
    if (bus.cpu_stall !== (act && owns)) begin
      bad++; $display("FAIL cpu_stall cyc=%0d got=%b exp=%b", cycleIdx, bus.cpu_stall, act && owns);
    end
    total++;
    if (bus.mem_we !== we) begin
      bad++; $display("FAIL mem_we cyc=%0d got=%b exp=%b", cycleIdx, bus.mem_we, we);
    end
    total++;
    if (bus.mem_addr !== addr) begin
      bad++; $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cycleIdx, bus.mem_addr, addr);
    end
    if (we) begin
      total++;
      if (bus.mem_wd !== bus.cpu_wd) begin
        bad++; $display("FAIL mem_wd cyc=%0d got=%h exp=%h", cycleIdx, bus.mem_wd, bus.cpu_wd);
      end
    end
    if (bus.cpu_re && !owns) begin
      total++;
      if (bus.cpu_rd !== refMem[bus.cpu_addr[11:2]]) begin
        bad++; $display("FAIL cpu_rd cyc=%0d got=%h exp=%h", cycleIdx, bus.cpu_rd, refMem[bus.cpu_addr[11:2]]);
      end
    end
    total++;
    if (bus.vga_valid !== (mFifo.size() != 0)) begin
      bad++; $display("FAIL vga_valid cyc=%0d got=%b exp=%b", cycleIdx, bus.vga_valid, mFifo.size() != 0);
    end
    if (mFifo.size() != 0) begin
      total++;
      if (bus.vga_data !== mFifo[0]) begin
        bad++; $display("FAIL vga_data cyc=%0d got=%h exp=%h", cycleIdx, bus.vga_data, mFifo[0]);
      end
    end
    total++;
    if (bus.vga_busy !== (mState != S_IDLE)) begin
      bad++; $display("FAIL vga_busy cyc=%0d got=%b exp=%b", cycleIdx, bus.vga_busy, mState != S_IDLE);
    end
    total++;
    if (bus.vga_done !== (mState == S_DONE)) begin
      bad++; $display("FAIL vga_done cyc=%0d got=%b exp=%b", cycleIdx, bus.vga_done, mState == S_DONE);
    end

    if (bus.vga_valid && bus.vga_ready) rxQ.push_back(bus.vga_data);
    if (bus.cpu_stall) stallLog.push_back(cycleIdx - stallBase + 1);
    if (bus.vga_done) doneCount++;
    if (bus.vga_busy) busyCount++;
    if (bus.mem_addr !== bus.cpu_addr) vgaIssues++;

    eAct = act; eCan = can; eOwns = owns; eWe = we; eAddr = addr;
  endtask

  // Advance the model by one clock using the rules of the arbiter.
  task automatic updateModel();
    int preSize;
    int preIssued;
    preSize   = mFifo.size();
    preIssued = mIssued;
    if (eWe) refMem[eAddr[11:2]] = bus.cpu_wd;
    if (preSize > 0 && bus.vga_ready) void'(mFifo.pop_front());
    if (eOwns) begin
      mFifo.push_back(refMem[eAddr[11:2]]);
      mIssued++;
    end
    if (!eAct) mRun = 0;
    else if (mState == S_BURST) begin
      if (eOwns) mRun = 0;
      else if (eCan) mRun++;
    end
    case (mState)
      S_IDLE: if (bus.vga_start) begin
        mState = S_BURST; mBase = bus.vga_base; mLen = int'(bus.vga_len); mIssued = 0;
      end
      S_BURST: if (preIssued == mLen) mState = S_DRAIN;
      S_DRAIN: if (preSize == 0) mState = S_DONE;
      default: mState = S_IDLE;
    endcase
    cycleIdx++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    checkCycle();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic idleCpu();
    bus.cpu_we = 1'b0; bus.cpu_re = 1'b0; bus.cpu_addr = 32'hFFC; bus.cpu_wd = 32'd0;
  endtask

  task automatic startBurst(input logic [31:0] base, input int len);
    bus.vga_start = 1'b1; bus.vga_base = base; bus.vga_len = 16'(len);
    tick();
    bus.vga_start = 1'b0;
  endtask

  task automatic runUntilIdle(input int maxCycles);
    int n;
    n = 0;
    while ((mState != S_IDLE || bus.vga_busy) && n < maxCycles) begin
      tick();
      n++;
    end
    total++;
    if (mState != S_IDLE || bus.vga_busy) begin
      bad++; $display("FAIL idle_timeout got_busy=%b exp_busy=0 after=%0d", bus.vga_busy, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.cpu_we = 1'b1; bus.cpu_addr = 32'h40; bus.cpu_wd = 32'h1234;
    #1;
    total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", bus.cpu_stall); end
    total++; if (bus.vga_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.vga_valid); end
    total++; if (bus.vga_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.vga_busy); end
    total++; if (bus.vga_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", bus.vga_done); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
    @(posedge clk); #1;
    memLoad = 1'b0;
    idleCpu();
    reset = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_cpu_only();
    bus.cpu_we = 1'b1; bus.cpu_re = 1'b0; bus.cpu_addr = 32'h40; bus.cpu_wd = 32'hDEAD_BEEF;
    tick();
    bus.cpu_we = 1'b0; bus.cpu_re = 1'b1; bus.cpu_wd = 32'd0;
    #2;
    total++;
    if (bus.cpu_rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL cpu_readback got=%h exp=deadbeef", bus.cpu_rd); end
    tick();
    for (int i = 0; i < 6; i++) begin
      bus.cpu_we = ($urandom_range(0, 1) == 1);
      bus.cpu_re = !bus.cpu_we;
      bus.cpu_addr = 32'($urandom_range(16, 31)) << 2;
      bus.cpu_wd = $urandom();
      tick();
    end
    idleCpu();
    tick();
  endtask

  task automatic test_burst_basic();
    rxQ.delete(); doneCount = 0;
    bus.vga_ready = 1'b1;
    startBurst(32'h100, 6);
    runUntilIdle(40);
    total++;
    if (rxQ.size() != 6) begin bad++; $display("FAIL burst6_count got=%0d exp=6", rxQ.size()); end
    for (int i = 0; i < rxQ.size() && i < 6; i++) begin
      total++;
      if (rxQ[i] !== refMem['h40 + i]) begin
        bad++; $display("FAIL burst6_word%0d got=%h exp=%h", i, rxQ[i], refMem['h40 + i]);
      end
    end
    total++;
    if (doneCount != 1) begin bad++; $display("FAIL burst6_done got=%0d exp=1", doneCount); end
  endtask

  task automatic test_fifo_full();
    rxQ.delete(); vgaIssues = 0;
    bus.vga_ready = 1'b0;
    startBurst(32'h180, 8);
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (vgaIssues != 4) begin bad++; $display("FAIL full_issues got=%0d exp=4", vgaIssues); end
    total++;
    if (bus.vga_valid !== 1'b1) begin bad++; $display("FAIL full_valid got=%b exp=1", bus.vga_valid); end
    bus.vga_ready = 1'b1;
    runUntilIdle(40);
    total++;
    if (rxQ.size() != 8) begin bad++; $display("FAIL full_count got=%0d exp=8", rxQ.size()); end
    for (int i = 0; i < rxQ.size() && i < 8; i++) begin
      total++;
      if (rxQ[i] !== refMem['h60 + i]) begin
        bad++; $display("FAIL full_word%0d got=%h exp=%h", i, rxQ[i], refMem['h60 + i]);
      end
    end
  endtask

  task automatic test_starvation();
    logic wr;
    int   diffs;
    rxQ.delete();
    bus.vga_ready = 1'b1;
    idleCpu();
    tick();
    startBurst(32'h300, 4);
    stallLog.delete();
    stallBase = cycleIdx;
    for (int i = 1; i <= 40; i++) begin
      wr = (i % 9 == 0) || ($urandom_range(0, 1) == 1);
      bus.cpu_we = wr; bus.cpu_re = !wr;
      bus.cpu_addr = 32'h200 + (32'($urandom_range(0, 63)) << 2);
      bus.cpu_wd = $urandom();
      tick();
    end
    idleCpu();
    runUntilIdle(20);
    total++;
    if (stallLog.size() != 4) begin bad++; $display("FAIL starve_stalls got=%0d exp=4", stallLog.size()); end
    for (int k = 0; k < stallLog.size() && k < 4; k++) begin
      total++;
      if (stallLog[k] != 9 * (k + 1)) begin
        bad++; $display("FAIL starve_stall%0d got=%0d exp=%0d", k, stallLog[k], 9 * (k + 1));
      end
    end
    total++;
    if (rxQ.size() != 4) begin bad++; $display("FAIL starve_count got=%0d exp=4", rxQ.size()); end
    for (int i = 0; i < rxQ.size() && i < 4; i++) begin
      total++;
      if (rxQ[i] !== refMem['hC0 + i]) begin
        bad++; $display("FAIL starve_word%0d got=%h exp=%h", i, rxQ[i], refMem['hC0 + i]);
      end
    end
    diffs = 0;
    for (int i = 'h80; i < 'hC0; i++) if (mem[i] !== refMem[i]) diffs++;
    total++;
    if (diffs != 0) begin bad++; $display("FAIL starve_memory got=%0d_diffs exp=0", diffs); end
  endtask

  task automatic test_zero_len();
    busyCount = 0; doneCount = 0; vgaIssues = 0;
    idleCpu();
    bus.vga_ready = 1'b1;
    startBurst(32'h80, 0);
    bus.vga_start = 1'b1; bus.vga_base = 32'h0; bus.vga_len = 16'd5;
    tick();
    bus.vga_start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (busyCount != 3) begin bad++; $display("FAIL zero_busy got=%0d exp=3", busyCount); end
    total++;
    if (doneCount != 1) begin bad++; $display("FAIL zero_done got=%0d exp=1", doneCount); end
    total++;
    if (vgaIssues != 0) begin bad++; $display("FAIL zero_mem_access got=%0d exp=0", vgaIssues); end
  endtask

  task automatic test_reset_midburst();
    doneCount = 0;
    idleCpu();
    bus.vga_ready = 1'b0;
    startBurst(32'h140, 8);
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    bus.cpu_we = 1'b1; bus.cpu_addr = 32'h20; bus.cpu_wd = 32'hBAD0_0001;
    #1;
    total++; if (bus.vga_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b exp=0", bus.vga_valid); end
    total++; if (bus.vga_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", bus.vga_busy); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL abort_mem_we got=%b exp=0", bus.mem_we); end
    total++; if (bus.vga_done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", bus.vga_done); end
    modelReset();
    @(posedge clk); #1;
    reset = 1'b1;
    idleCpu();
    tick();
    tick();
    total++;
    if (doneCount != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", doneCount); end
    rxQ.delete();
    bus.vga_ready = 1'b1;
    startBurst(32'h1C0, 3);
    runUntilIdle(20);
    total++;
    if (rxQ.size() != 3) begin bad++; $display("FAIL fresh_count got=%0d exp=3", rxQ.size()); end
    for (int i = 0; i < rxQ.size() && i < 3; i++) begin
      total++;
      if (rxQ[i] !== refMem['h70 + i]) begin
        bad++; $display("FAIL fresh_word%0d got=%h exp=%h", i, rxQ[i], refMem['h70 + i]);
      end
    end
    total++;
    if (doneCount != 1) begin bad++; $display("FAIL fresh_done got=%0d exp=1", doneCount); end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 300; c++) begin
      r = $urandom_range(0, 9);
      bus.cpu_we    = (r < 3);
      bus.cpu_re    = (r >= 3 && r < 6);
      bus.cpu_addr  = 32'($urandom_range(0, 1023)) << 2;
      bus.cpu_wd    = $urandom();
      bus.vga_ready = ($urandom_range(0, 3) != 0);
      bus.vga_start = ($urandom_range(0, 11) == 0);
      bus.vga_base  = 32'($urandom_range(0, 900)) << 2;
      bus.vga_len   = 16'($urandom_range(0, 10));
      tick();
    end
    idleCpu();
    bus.vga_start = 1'b0;
    bus.vga_ready = 1'b1;
    runUntilIdle(100);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    total = 0; bad = 0; cycleIdx = 0; stallBase = 0;
    doneCount = 0; busyCount = 0; vgaIssues = 0;
    memLoad = 1'b1;
    reset = 1'b1;
    bus.cpu_we = 1'b0; bus.cpu_re = 1'b0; bus.cpu_addr = 32'd0; bus.cpu_wd = 32'd0;
    bus.vga_start = 1'b0; bus.vga_base = 32'd0; bus.vga_len = 16'd0; bus.vga_ready = 1'b0;
    for (int i = 0; i < 1024; i++) refMem[i] = pat(i);
    modelReset();
    #1;
    reset = 1'b0;

    test_reset();
    test_cpu_only();
    test_burst_basic();
    test_fifo_full();
    test_starvation();
    test_zero_len();
    test_reset_midburst();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
